// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared constants and types for the LED group blank controller
//   Contents: group count and width, default debounce/blink periods,
//             group mask type, debounce state encoding.
package led_ctrl_pkg;

  localparam int N_GRP_DEF           = 4;
  localparam int GRP_WIDTH           = 4;         // LEDs per group
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;   // 10 ms at 100 MHz
  localparam int BLINK_CYCLES_DEF    = 25000000;  // blink half-period

  typedef logic [N_GRP_DEF-1:0] grp_mask_t;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_CHANGING = 1'b1
  } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - single push button synchroniser, debouncer and press detector
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   btn_i   in  raw asynchronous button, active-high
//   pulse_o out one-cycle pulse, the cycle after the debounced level rises
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_e        db_state;

  always_comb begin
    sync1_d      = btn_i;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = cnt_q;
    // Rising edge of the debounced level, registered once more so the
    // pulse lands one cycle after stable goes high.
    pulse_d      = stable_q & ~stable_dly_q;

    db_state = (sync2_q == stable_q) ? DB_STABLE : DB_CHANGING;

    case (db_state)
      DB_STABLE: begin
        cnt_d = '0;
      end
      DB_CHANGING: begin
        // Accept at CNT_MAX; the counter is cleared here so it never wraps.
        if (cnt_q == CNT_MAX) begin
          stable_d = sync2_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      pulse_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pulse_q      <= pulse_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/led_grp_blank_ctrl.sv
// rtl/led_grp_blank_ctrl.sv - per-group LED blank mask driven by debounced toggle buttons
//   Optional feature macro: LED_GRP_BLINK_EN (blanked groups blink instead of staying off)
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   btn_i       in  raw push buttons, one per group
//   clr_i       in  synchronous clear of all blank bits (wins over presses)
//   grp_blank_o out per-group blank, 1 = group LEDs off
//   btn_pulse_o out one-cycle pulse per accepted press
module led_grp_blank_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_GRP           = N_GRP_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BLINK_CYCLES    = BLINK_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_GRP-1:0] btn_i,
  input  logic             clr_i,
  output logic [N_GRP-1:0] grp_blank_o,
  output logic [N_GRP-1:0] btn_pulse_o
);

  logic [N_GRP-1:0] pulse;
  logic [N_GRP-1:0] mask_q, mask_d;

  for (genvar gi = 0; gi < N_GRP; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_i[gi]),
      .pulse_o(pulse[gi])
    );
  end

  assign btn_pulse_o = pulse;

  // Each pulse toggles its own bit; clear overrides any same-cycle toggle.
  always_comb begin
    mask_d = mask_q ^ pulse;
    if (clr_i) begin
      mask_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

`ifdef LED_GRP_BLINK_EN
  localparam int               BLK_W   = $clog2(BLINK_CYCLES);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_CYCLES - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [N_GRP-1:0] blank_q, blank_d;

  // Free-running; clr_i deliberately leaves the phase alone.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BLK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    // Built from next-state values so the output register adds no latency
    // over the plain mask path.
    blank_d = mask_d & ~{N_GRP{phase_d}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blank_q     <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blank_q     <= blank_d;
    end
  end

  assign grp_blank_o = blank_q;
`else
  assign grp_blank_o = mask_q;
`endif

endmodule

// File: tb/tb_led_grp_blank_ctrl.sv
// tb/tb_led_grp_blank_ctrl.sv - self-checking bench for led_grp_blank_ctrl
module tb_led_grp_blank_ctrl;

  localparam int DEB   = 4;
  localparam int BLINK = 8;
  localparam int LAT   = 2 + DEB + 1;

  typedef struct {
    logic [3:0] pulse;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_i;
  logic       clr_i;
  logic [3:0] grp_blank_o;
  logic [3:0] btn_pulse_o;

  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   rel_cyc = 0;
  exp_t exp_q[$];

  led_grp_blank_ctrl #(
    .N_GRP          (4),
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES   (BLINK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (btn_i),
    .clr_i      (clr_i),
    .grp_blank_o(grp_blank_o),
    .btn_pulse_o(btn_pulse_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] blank_of(input logic [3:0] m);
`ifdef LED_GRP_BLINK_EN
    if ((((cyc - rel_cyc) / BLINK) % 2) == 1) return 4'b0000;
    return m;
`else
    return m;
`endif
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [3:0] p);
    exp_t e;
    e.pulse = p;
    e.cyc   = cyc + LAT;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every non-zero pulse must match the oldest expected pulse,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    if (btn_pulse_o !== 4'b0000) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse observed=%b expected=none (cycle %0d)", btn_pulse_o, cyc);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        assert (btn_pulse_o === e.pulse && cyc == e.cyc) else begin
          errors++;
          $error("FAIL pulse observed=%b@%0d expected=%b@%0d", btn_pulse_o, cyc, e.pulse, e.cyc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    btn_i = 4'b1111;
    clr_i = 1'b0;

    // 1: outputs quiet during reset, then held buttons all fire once
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_blank", grp_blank_o, 4'b0000);
      check("rst_pulse", btn_pulse_o, 4'b0000);
    end
    rst_n   = 1'b1;
    rel_cyc = cyc;
    expect_pulse(4'b1111);
    tick(LAT);
    check("t1_pre_blank", grp_blank_o, blank_of(4'b0000));
    tick(1);
    check("t1_blank", grp_blank_o, blank_of(4'b1111));
    btn_i = 4'b0000;
    tick(10);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    check("clr_all", grp_blank_o, 4'b0000);

    // 2: clean press on button 2, then a second press/release
    btn_i = 4'b0100;
    expect_pulse(4'b0100);
    tick(LAT);
    check("t2_pre", grp_blank_o, blank_of(4'b0000));
    tick(1);
    check("t2_set", grp_blank_o, blank_of(4'b0100));
    tick(2);
    btn_i = 4'b0000;
    tick(10);
    check("t2_release", grp_blank_o, blank_of(4'b0100));
    btn_i = 4'b0100;
    expect_pulse(4'b0100);
    tick(LAT + 1);
    check("t2_second", grp_blank_o, blank_of(4'b0000));
    btn_i = 4'b0000;
    tick(10);

    // 3: bounce shorter than the debounce window is ignored
    for (int i = 0; i < 10; i++) begin
      btn_i[0] = ~btn_i[0];
      tick(2);
    end
    btn_i = 4'b0000;
    tick(12);
    check("t3_bounce", grp_blank_o, blank_of(4'b0000));

    // 4: simultaneous presses, then clear racing a press
    btn_i = 4'b1010;
    expect_pulse(4'b1010);
    tick(LAT + 1);
    check("t4_simul", grp_blank_o, blank_of(4'b1010));
    btn_i = 4'b0000;
    tick(10);
    btn_i = 4'b0001;
    expect_pulse(4'b0001);
    tick(LAT);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    check("t4_clr_wins", grp_blank_o, 4'b0000);
    btn_i = 4'b0000;
    tick(10);
    check("t4_clr_hold", grp_blank_o, 4'b0000);

    // 5: reset in the middle of a debounce discards the partial count
    btn_i = 4'b0001;
    tick(2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_blank", grp_blank_o, 4'b0000);
    check("t5_rst_pulse", btn_pulse_o, 4'b0000);
    tick(2);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    expect_pulse(4'b0001);
    tick(LAT);
    check("t5_pre", grp_blank_o, blank_of(4'b0000));
    tick(1);
    check("t5_after", grp_blank_o, blank_of(4'b0001));

    // 6: button still held (no further pulses); blanked group blinks when enabled
    for (int i = 0; i < 4 * BLINK; i++) begin
      tick(1);
      check("t6_blank", grp_blank_o, blank_of(4'b0001));
    end
    btn_i = 4'b0000;
    tick(10);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL pending_pulses observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
